// File: rtl/wb_interconnect.sv
// Single-master, NS-slave pipelined Wishbone interconnect with address decode and in-order response tracking.
// Define WB_IC_TIMEOUT_EN to add a watchdog that returns wb_err when the active slave never answers.
module wb_interconnect #(
    parameter int               NS         = 4,
    parameter int               AW         = 30,
    parameter int               DW         = 32,
    parameter int               DEPTH      = 4,
    parameter logic [NS*AW-1:0] SLAVE_BASE = '0,
    parameter logic [NS*AW-1:0] SLAVE_MASK = '0,
    parameter int               TIMEOUT    = 255
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              wb_cyc,
    input  logic              wb_stb,
    input  logic              wb_we,
    input  logic [AW-1:0]     wb_addr,
    input  logic [DW-1:0]     wb_mosi,
    input  logic [DW/8-1:0]   wb_sel,
    output logic              wb_ack,
    output logic              wb_err,
    output logic              wb_stall,
    output logic [DW-1:0]     wb_miso,
    output logic [NS-1:0]     s_cyc,
    output logic [NS-1:0]     s_stb,
    output logic              s_we,
    output logic [AW-1:0]     s_addr,
    output logic [DW-1:0]     s_mosi,
    output logic [DW/8-1:0]   s_sel,
    input  logic [NS-1:0]     s_ack,
    input  logic [NS-1:0]     s_stall,
    input  logic [NS-1:0]     s_err,
    input  logic [NS*DW-1:0]  s_data
);
    localparam int            OW      = $clog2(DEPTH + 1);
    localparam int            IW      = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);

    logic [OW-1:0] outstanding;
    logic [IW-1:0] active;
    logic [IW-1:0] target;
    logic          mapped;
    logic          busy;
    logic          blocked;
    logic          accept;
    logic          resp_ack;
    logic          resp_err;
    logic          resp;
    logic          wd_fire;
    logic [DW-1:0] active_data;

    // Descending scan so the lowest-index hit is the one left standing.
    always_comb begin
        target = '0;
        mapped = 1'b0;
        for (int k = NS - 1; k >= 0; k--) begin
            if ((wb_addr & SLAVE_MASK[k*AW +: AW]) == (SLAVE_BASE[k*AW +: AW] & SLAVE_MASK[k*AW +: AW])) begin
                target = IW'(k);
                mapped = 1'b1;
            end
        end
    end

    always_comb begin
        active_data = '0;
        for (int k = 0; k < NS; k++) begin
            if (active == IW'(k))
                active_data = s_data[k*DW +: DW];
        end
    end

    assign busy     = (outstanding != '0);
    assign blocked  = (outstanding == DEPTH_C) || (busy && (!mapped || target != active));
    assign wb_stall = wb_stb && (blocked || (mapped && s_stall[target]));
    assign accept   = wb_stb && !wb_stall;
    assign resp_ack = busy && s_ack[active];
    assign resp_err = busy && s_err[active];
    assign resp     = resp_ack || resp_err;

    assign s_cyc  = {NS{wb_cyc}};
    assign s_we   = wb_we;
    assign s_addr = wb_addr;
    assign s_mosi = wb_mosi;
    assign s_sel  = wb_sel;

    always_comb begin
        s_stb = '0;
        if (wb_stb && mapped && !blocked)
            s_stb[target] = 1'b1;
    end

`ifdef WB_IC_TIMEOUT_EN
    localparam int            TW      = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] wd_cnt;

    // Fires on the edge where the idle count would reach TIMEOUT.
    assign wd_fire = busy && !accept && !resp && (wd_cnt == WD_LAST);

    always_ff @(posedge i_clk) begin
        if (i_reset || !wb_cyc || !busy || accept || resp || wd_fire)
            wd_cnt <= '0;
        else if (wd_cnt != '1)
            wd_cnt <= wd_cnt + TW'(1);
    end
`else
    assign wd_fire = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            outstanding <= '0;
            active      <= '0;
            wb_ack      <= 1'b0;
            wb_err      <= 1'b0;
            wb_miso     <= '0;
        end else begin
            wb_ack  <= wb_cyc && resp_ack;
            wb_err  <= wb_cyc && (resp_err || (accept && !mapped) || wd_fire);
            wb_miso <= (wb_cyc && resp_ack) ? active_data : '0;
            if (accept && mapped)
                active <= target;
            if (!wb_cyc || wd_fire)
                outstanding <= '0;
            else if (accept && mapped && !resp && outstanding != DEPTH_C)
                outstanding <= outstanding + OW'(1);
            else if (resp && !(accept && mapped))
                outstanding <= outstanding - OW'(1);
        end
    end
endmodule

// File: tb/tb_wb_interconnect.sv
// Self-checking bench for wb_interconnect: decode vector table, directed multi-cycle sequences,
// and a randomized run checked against a transaction-level slave/master model.
module tb_wb_interconnect;
    localparam int NS = 4, AW = 30, DW = 32, DEPTH = 4, TIMEOUT = 8;
    // slot0: field 0, slot1: field 1 odd, slot2: field 1 any, slot3: field 2 (field = addr[17:14])
    localparam logic [NS*AW-1:0] BASE = {30'h08000, 30'h04000, 30'h04001, 30'h00000};
    localparam logic [NS*AW-1:0] MASK = {30'h3C000, 30'h3C000, 30'h3C001, 30'h3C000};

    logic              i_clk, i_reset;
    logic              wb_cyc, wb_stb, wb_we;
    logic [AW-1:0]     wb_addr;
    logic [DW-1:0]     wb_mosi;
    logic [DW/8-1:0]   wb_sel;
    logic              wb_ack, wb_err, wb_stall;
    logic [DW-1:0]     wb_miso;
    logic [NS-1:0]     s_cyc, s_stb;
    logic              s_we;
    logic [AW-1:0]     s_addr;
    logic [DW-1:0]     s_mosi;
    logic [DW/8-1:0]   s_sel;
    logic [NS-1:0]     s_ack, s_stall, s_err;
    logic [NS*DW-1:0]  s_data;

    wb_interconnect #(
        .NS(NS), .AW(AW), .DW(DW), .DEPTH(DEPTH),
        .SLAVE_BASE(BASE), .SLAVE_MASK(MASK), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
        .wb_addr(wb_addr), .wb_mosi(wb_mosi), .wb_sel(wb_sel),
        .wb_ack(wb_ack), .wb_err(wb_err), .wb_stall(wb_stall), .wb_miso(wb_miso),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_addr(s_addr),
        .s_mosi(s_mosi), .s_sel(s_sel),
        .s_ack(s_ack), .s_stall(s_stall), .s_err(s_err), .s_data(s_data)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          stb;
        logic [NS-1:0] stall;
        logic          exp_stall;
        logic [NS-1:0] exp_sstb;
    } vec_t;

    typedef struct packed {
        logic [1:0]    slave;
        logic [DW-1:0] data;
    } rsp_t;

    int            n_cmp, n_bad;
    vec_t          vecs [9];
    rsp_t          rq [$];
    logic [DW-1:0] bq [$];
    rsp_t          r;
    int            acc, nack, t, rdly, f, sel;
    logic          hold, eblk, estall, eacc, e_ack, e_err;
    logic [DW-1:0] e_miso;
    logic [AW-1:0] a;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Decode straight from the address map: -1 means unmapped.
    function automatic int ref_slave(input logic [AW-1:0] ad);
        case (ad[17:14])
            4'd0:    return 0;
            4'd1:    return ad[0] ? 1 : 2;
            4'd2:    return 3;
            default: return -1;
        endcase
    endfunction

    function automatic logic [DW-1:0] dfun(input int k, input logic [AW-1:0] ad);
        return {k[1:0], ad};
    endfunction

    task automatic accept_one(input logic [AW-1:0] ad, input string name);
        wb_addr = ad;
        wb_stb  = 1'b1;
        #1;
        chk(name, wb_stall, 1'b0);
        tick();
        wb_stb = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp = 0; n_bad = 0;
        i_reset = 1'b1; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        wb_addr = '0; wb_mosi = 32'h1234_5678; wb_sel = 4'hF;
        s_ack = '0; s_err = '0; s_stall = '0; s_data = '0;
        rdly = 0; hold = 1'b0; e_ack = 1'b0; e_err = 1'b0; e_miso = '0;

        vecs[0] = '{30'h00010, 1'b1, 4'b0000, 1'b0, 4'b0001};
        vecs[1] = '{30'h04001, 1'b1, 4'b0000, 1'b0, 4'b0010};
        vecs[2] = '{30'h04000, 1'b1, 4'b0000, 1'b0, 4'b0100};
        vecs[3] = '{30'h08123, 1'b1, 4'b0000, 1'b0, 4'b1000};
        vecs[4] = '{30'h3FFFFFF0, 1'b1, 4'b0000, 1'b0, 4'b0000};
        vecs[5] = '{30'h00010, 1'b1, 4'b0001, 1'b1, 4'b0001};
        vecs[6] = '{30'h04000, 1'b1, 4'b0001, 1'b0, 4'b0100};
        vecs[7] = '{30'h00010, 1'b0, 4'b1111, 1'b0, 4'b0000};
        vecs[8] = '{30'h0C000, 1'b1, 4'b1111, 1'b0, 4'b0000};

        repeat (3) tick();
        i_reset = 1'b0;
        wb_cyc  = 1'b1;
        #1;
        chk("rst_ack", wb_ack, 1'b0);
        chk("rst_err", wb_err, 1'b0);
        chk("rst_miso", wb_miso, 32'h0);
        chk("rst_stall", wb_stall, 1'b0);
        chk("rst_sstb", s_stb, 4'b0000);
        chk("fanout_mosi", s_mosi, wb_mosi);

        for (int i = 0; i < 9; i++) begin
            wb_addr = vecs[i].addr; wb_stb = vecs[i].stb; s_stall = vecs[i].stall;
            #1;
            chk($sformatf("vec%0d_stall", i), wb_stall, vecs[i].exp_stall);
            chk($sformatf("vec%0d_sstb", i), s_stb, vecs[i].exp_sstb);
            chk($sformatf("vec%0d_scyc", i), s_cyc, 4'b1111);
            wb_stb = 1'b0; s_stall = '0;
            tick();
        end

        // single read
        accept_one(30'h10, "rd_stall");
        s_ack[0] = 1'b1; s_data[31:0] = 32'hDEADBEEF;
        #1;
        chk("rd_ack_early", wb_ack, 1'b0);
        tick();
        chk("rd_ack", wb_ack, 1'b1);
        chk("rd_miso", wb_miso, 32'hDEADBEEF);
        chk("rd_err", wb_err, 1'b0);
        s_ack = '0; s_data = '0;
        tick();
        chk("rd_ack_once", wb_ack, 1'b0);
        chk("rd_miso_clr", wb_miso, 32'h0);
        wb_addr = 30'h04000; wb_stb = 1'b1;
        #1;
        chk("rd_drained", wb_stall, 1'b0);
        wb_stb = 1'b0;
        tick();

        // depth-limited burst
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            wb_addr = 30'h100 + AW'(acc); wb_stb = 1'b1;
            #1;
            chk($sformatf("burst_stall%0d", c), wb_stall, c >= 4);
            if (!wb_stall) begin
                bq.push_back(32'hA000_0000 + acc);
                acc++;
            end
            tick();
        end
        nack = 0;
        for (int c = 0; c < 20 && nack < 6; c++) begin
            wb_stb  = (acc < 6);
            wb_addr = 30'h100 + AW'(acc);
            s_ack[0] = (bq.size() > 0);
            s_data[31:0] = (bq.size() > 0) ? bq[0] : 32'h0;
            #1;
            if (c == 0) chk("burst_p0_stall", wb_stall, 1'b1);
            if (c == 1) chk("burst_p1_stall", wb_stall, 1'b0);
            if (s_ack[0]) void'(bq.pop_front());
            if (wb_stb && !wb_stall) begin
                bq.push_back(32'hA000_0000 + acc);
                acc++;
            end
            tick();
            if (wb_ack) begin
                chk("burst_data", wb_miso, 32'hA000_0000 + nack);
                nack++;
            end
        end
        wb_stb = 1'b0; s_ack = '0;
        chk("burst_acks", nack, 6);
        chk("burst_accepts", acc, 6);
        tick();

        // slave switch
        accept_one(30'h200, "sw_acc0");
        accept_one(30'h201, "sw_acc1");
        wb_addr = 30'h04001; wb_stb = 1'b1;
        for (int c = 0; c < 4; c++) begin
            s_ack[0] = (c == 1 || c == 2);
            s_data[31:0] = 32'h5000 + c;
            #1;
            chk($sformatf("sw_stall%0d", c), wb_stall, c < 3);
            chk($sformatf("sw_sstb%0d", c), s_stb, (c < 3) ? 4'b0000 : 4'b0010);
            tick();
            chk($sformatf("sw_ack%0d", c), wb_ack, c == 1 || c == 2);
            chk($sformatf("sw_miso%0d", c), wb_miso, (c == 1 || c == 2) ? 32'h5000 + c : 32'h0);
        end
        wb_stb = 1'b0; s_ack = '0; s_ack[1] = 1'b1; s_data[63:32] = 32'h1111;
        tick();
        chk("sw_s1_ack", wb_ack, 1'b1);
        chk("sw_s1_miso", wb_miso, 32'h1111);
        s_ack = '0; s_data = '0;
        tick();

        // unmapped
        wb_addr = 30'h3FFF_FFF0; wb_stb = 1'b1;
        #1;
        chk("um_stall", wb_stall, 1'b0);
        chk("um_sstb", s_stb, 4'b0000);
        tick();
        wb_stb = 1'b0;
        chk("um_err", wb_err, 1'b1);
        chk("um_ack", wb_ack, 1'b0);
        chk("um_miso", wb_miso, 32'h0);
        tick();
        chk("um_err_once", wb_err, 1'b0);

`ifdef WB_IC_TIMEOUT_EN
        accept_one(30'h300, "wd_acc");
        for (int n = 1; n <= 10; n++) begin
            tick();
            chk($sformatf("wd_err%0d", n), wb_err, n == 8);
        end
        s_ack[0] = 1'b1;
        tick();
        chk("wd_late_ack", wb_ack, 1'b0);
        s_ack = '0;
        wb_addr = 30'h04001; wb_stb = 1'b1;
        #1;
        chk("wd_cleared", wb_stall, 1'b0);
        wb_stb = 1'b0;
        tick();
`else
        accept_one(30'h300, "nowd_acc");
        wb_addr = 30'h04001; wb_stb = 1'b1;
        for (int n = 0; n < 20; n++) begin
            #1;
            chk($sformatf("nowd_stall%0d", n), wb_stall, 1'b1);
            tick();
            chk($sformatf("nowd_err%0d", n), wb_err, 1'b0);
        end
        wb_stb = 1'b0; wb_cyc = 1'b0;
        tick();
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
        #1;
        chk("nowd_cleared", wb_stall, 1'b0);
        wb_stb = 1'b0;
        tick();
`endif

        // abort via wb_cyc
        accept_one(30'h400, "ab_acc0");
        accept_one(30'h401, "ab_acc1");
        wb_cyc = 1'b0; s_ack[0] = 1'b1; s_data[31:0] = 32'hBAD0;
        #1;
        chk("ab_scyc", s_cyc, 4'b0000);
        tick();
        chk("ab_ack", wb_ack, 1'b0);
        chk("ab_err", wb_err, 1'b0);
        wb_cyc = 1'b1;
        tick();
        chk("ab_late_ack", wb_ack, 1'b0);
        s_ack = '0;
        wb_addr = 30'h04001; wb_stb = 1'b1;
        #1;
        chk("ab_cleared", wb_stall, 1'b0);
        wb_stb = 1'b0;
        tick();

        // reset mid-transaction
        accept_one(30'h500, "rs_acc0");
        accept_one(30'h501, "rs_acc1");
        i_reset = 1'b1; s_ack[0] = 1'b1; s_data[31:0] = 32'hBAD1;
        tick();
        i_reset = 1'b0;
        chk("rs_ack", wb_ack, 1'b0);
        chk("rs_err", wb_err, 1'b0);
        chk("rs_miso", wb_miso, 32'h0);
        tick();
        chk("rs_late_ack", wb_ack, 1'b0);
        s_ack = '0; s_data = '0;
        wb_addr = 30'h04001; wb_stb = 1'b1;
        #1;
        chk("rs_cleared", wb_stall, 1'b0);
        wb_stb = 1'b0;
        tick();

        // randomized traffic against the transaction-level model
        for (int cyc = 0; cyc < 1500; cyc++) begin
            chk("rnd_ack", wb_ack, e_ack);
            chk("rnd_err", wb_err, e_err);
            chk("rnd_miso", wb_miso, e_miso);
            if (!hold) begin
                wb_stb = (cyc < 1480) && ($urandom_range(0, 9) < 7);
                a = AW'($urandom);
                sel = $urandom_range(0, 9);
                if (sel <= 2)      f = 0;
                else if (sel <= 6) f = 1;
                else if (sel <= 8) f = 2;
                else               f = $urandom_range(3, 15);
                a[17:14] = f[3:0];
                if (sel == 3 || sel == 4) a[0] = 1'b1;
                if (sel == 5 || sel == 6) a[0] = 1'b0;
                wb_addr = a;
            end
            for (int k = 0; k < NS; k++) s_stall[k] = ($urandom_range(0, 3) == 0);
            s_ack = '0; s_err = '0;
            s_data = {$urandom, $urandom, $urandom, $urandom};
            if (rq.size() > 0 && rdly == 0) begin
                if ($urandom_range(0, 7) == 0) s_err[rq[0].slave] = 1'b1;
                else                           s_ack[rq[0].slave] = 1'b1;
                s_data[rq[0].slave*DW +: DW] = rq[0].data;
            end
            #1;
            t      = ref_slave(wb_addr);
            eblk   = (rq.size() == DEPTH) || (rq.size() > 0 && (t < 0 || t != int'(rq[rq.size()-1].slave)));
            estall = wb_stb && (eblk || (t >= 0 && s_stall[t]));
            chk("rnd_stall", wb_stall, estall);
            chk("rnd_sstb", s_stb, (wb_stb && t >= 0 && !eblk) ? (4'b0001 << t) : 4'b0000);
            eacc   = wb_stb && !estall;
            e_ack = 1'b0; e_err = 1'b0; e_miso = '0;
            if (s_ack != '0 || s_err != '0) begin
                e_ack  = (s_ack != '0);
                e_err  = (s_err != '0);
                e_miso = e_ack ? rq[0].data : '0;
                void'(rq.pop_front());
                rdly = $urandom_range(0, 2);
            end else if (rq.size() > 0) begin
                rdly--;
            end
            if (eacc) begin
                if (t < 0) begin
                    e_err = 1'b1;
                end else begin
                    r.slave = t[1:0];
                    r.data  = dfun(t, wb_addr);
                    rq.push_back(r);
                end
            end
            hold = wb_stb && estall;
            tick();
        end
        chk("rnd_drained", rq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
